mux4_bus_arbiter: RTL and testbench
===================================

// Module: mux4_bus_arbiter
// PURPOSE
//  Round-robin arbiter that shares one 32-bit resource (e.g. the data-memory port)
//  between four requesters. It drives the 2-bit select of the 4:1 datapath mux that
//  sits in front of that resource, and holds each grant until the resource acks.
//  A per-transaction timeout keeps a dead resource from locking the bus.
//  Sits between the core's memory requesters (IF, LSU, debug, DMA) and the memory port.
// PARAMETERS
//  TIMEOUT  16  Busy cycles without ack before abort; 0 disables the timeout.
//  CNT_W    5   Width of the timeout counter; must satisfy 2**CNT_W > TIMEOUT.
// PORTS
//  clk        in   1  Single clock; everything is on the rising edge.
//  rst_n      in   1  Asynchronous reset, active low.
//  req        in   4  Request per requester; held high until its done or err pulse.
//  gnt        out  4  One-hot grant; all zeros when idle.
//  sel        out  2  Select to the 4:1 datapath mux; equals the index of the gnt bit.
//  bus_valid  out  1  High while a granted transaction is outstanding.
//  bus_ack    in   1  Resource completes the current transaction (1-cycle pulse).
//  done       out  4  1-cycle pulse to the requester whose transaction was acked.
//  err        out  4  1-cycle pulse to the requester whose transaction timed out.
//  busy       out  1  High in the BUSY state (same as bus_valid; kept for status).
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, gnt=0, sel=0, bus_valid=0, busy=0, done=0,
//   err=0, cnt=0, last=3 (so requester 0 has top priority first). A reset in the
//   middle of a transaction aborts it silently: no done or err pulse is generated.
//  States:
//  IDLE: if req!=0, pick the first set bit searching last+1, last+2, ... (mod 4).
//   Next edge: gnt=onehot(pick), sel=pick, bus_valid=1, cnt=0, go to BUSY.
//   Latency from req to gnt is 1 cycle. If req==0, stay in IDLE; sel keeps its value.
//  BUSY: gnt, sel and bus_valid stay stable; changes on req are ignored.
//   - bus_ack=1: done[sel] pulses on the next edge, gnt=0, bus_valid=0,
//     last=sel, go to IDLE.
//   - else if TIMEOUT!=0 and cnt==TIMEOUT-1: err[sel] pulses on the next edge,
//     gnt=0, bus_valid=0, last=sel, go to IDLE.
//   - else cnt=cnt+1 (saturates; it cannot wrap because of the CNT_W rule).
//   - If ack and timeout happen in the same cycle, ack wins: done pulses, err does not.
//  Exactly one bubble cycle in IDLE between transactions. Peak rate is one
//   transaction per (ack latency + 2) cycles.
//  done and err are registered, one-hot or zero, and never both non-zero.
//  bus_ack seen in IDLE is ignored; no pulse is generated.
//  Fairness: a requester that holds req is granted within 3 other transactions.
//  sel is registered and changes only on an IDLE->BUSY edge, so it is glitch-free.
// STRUCTURE
//  arb_defs.vh (shared include): NUM_REQ=4, SEL_W=2, state encodings
//   ST_IDLE=1'b0 and ST_BUSY=1'b1.
//  Sub-module rr_pick4: combinational logic (req[3:0], last[1:0]) -> (any, pick[1:0]).
//   It rotates req by last+1, applies a fixed priority, then rotates back.
//  Top level: state register, cnt, last, output registers. Instantiate mux4 next to it.
// TESTING
//  1. req=4'b0001, ack 3 cycles after gnt -> gnt=0001 at +1 cycle, sel=0, done[0]
//     pulses once, then back to IDLE; bus_valid is high for exactly 4 cycles.
//  2. req=4'b1111 held, ack 1 cycle after each gnt -> grant order 0,1,2,3,0;
//     one IDLE bubble between grants.
//  3. TIMEOUT=16, req=4'b0100, never ack -> err[2] pulses 16 cycles after gnt rises;
//     done stays 0; the next grant goes to a requester other than 2 if one is pending.
//  4. Ack arrives in the same cycle as the timeout -> done pulses, err stays 0.
//  5. rst_n low for 1 cycle while BUSY with sel=3 -> all outputs take their reset
//     values immediately; no done or err; the next grant goes to requester 0.
//  6. TIMEOUT=0, no ack for 1000 cycles -> gnt stays held; err never pulses;
//     bus_ack in IDLE produces no pulse.

Source files
------------

// File: rtl/mux4_bus_arbiter_pkg.sv
// Shared definitions for the four-requester round-robin bus arbiter:
// requester count, select width, FSM state encoding and a one-hot helper.
package mux4_bus_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    // One-hot vector with bit 'idx' set; used for gnt, done and err.
    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/mux4_bus_arbiter_rr_pick4.sv
// Round-robin pick: rotates the request vector so that requester last+1 sits
// at bit 0, takes the lowest set bit, then rotates the index back.
module mux4_bus_arbiter_rr_pick4
    import mux4_bus_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   last,
    output logic               any,
    output logic [SEL_W-1:0]   pick
);

    logic [SEL_W-1:0]     w_rot_amt;
    logic [2*NUM_REQ-1:0] w_dbl;
    logic [NUM_REQ-1:0]   w_rot;
    logic [SEL_W-1:0]     w_idx;

    // Rotation amount wraps naturally: last=3 gives 0, i.e. requester 0 first.
    assign w_rot_amt = last + SEL_W'(1);
    assign w_dbl     = {req, req};
    assign w_rot     = w_dbl[w_rot_amt +: NUM_REQ];

    // Fixed priority on the rotated vector: lowest index wins.
    always_comb begin
        w_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) w_idx = SEL_W'(i);
        end
    end

    assign pick = w_idx + w_rot_amt;
    assign any  = |req;

endmodule

// File: rtl/mux4_bus_arbiter.sv
// Round-robin arbiter for one shared resource with four requesters. Holds each
// grant until bus_ack, aborts a transaction after TIMEOUT unacked busy cycles,
// and drives the registered select of the 4:1 datapath mux in front of the
// resource.
module mux4_bus_arbiter
    import mux4_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [SEL_W-1:0]   sel,
    output logic               bus_valid,
    input  logic               bus_ack,
    output logic [NUM_REQ-1:0] done,
    output logic [NUM_REQ-1:0] err,
    output logic               busy
);

    arb_state_e         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [SEL_W-1:0]   r_last;
    logic [SEL_W-1:0]   r_sel;
    logic [NUM_REQ-1:0] r_done;
    logic [NUM_REQ-1:0] r_err;

    arb_state_e         w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [SEL_W-1:0]   w_last_nxt;
    logic [SEL_W-1:0]   w_sel_nxt;
    logic [NUM_REQ-1:0] w_done_nxt;
    logic [NUM_REQ-1:0] w_err_nxt;

    logic               w_any;
    logic [SEL_W-1:0]   w_pick;
    logic               w_timeout_hit;

    mux4_bus_arbiter_rr_pick4 u_pick (
        .req  (req),
        .last (r_last),
        .any  (w_any),
        .pick (w_pick)
    );

    // A zero TIMEOUT disables the abort path entirely.
    assign w_timeout_hit = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));

    // Next-state and next-output logic; ack takes precedence over timeout.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves a value
        // unassigned, which would otherwise infer a latch.
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last;
        w_sel_nxt   = r_sel;
        w_done_nxt  = '0;
        w_err_nxt   = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_nxt = ST_BUSY;
                    w_sel_nxt   = w_pick;
                    w_cnt_nxt   = '0;
                end
            end
            ST_BUSY: begin
                if (bus_ack) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = onehot(r_sel);
                    w_last_nxt  = r_sel;
                end else if (w_timeout_hit) begin
                    w_state_nxt = ST_IDLE;
                    w_err_nxt   = onehot(r_sel);
                    w_last_nxt  = r_sel;
                end else if (r_cnt != {CNT_W{1'b1}}) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State and output registers; reset aborts silently and favours requester 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_last  <= SEL_W'(NUM_REQ - 1);
            r_sel   <= '0;
            r_done  <= '0;
            r_err   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_last  <= w_last_nxt;
            r_sel   <= w_sel_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign gnt       = (r_state == ST_BUSY) ? onehot(r_sel) : '0;
    assign sel       = r_sel;
    assign bus_valid = (r_state == ST_BUSY);
    assign busy      = (r_state == ST_BUSY);
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_mux4_bus_arbiter.sv
// Self-checking bench for mux4_bus_arbiter. A TIMEOUT=16 instance carries most
// scenarios; a TIMEOUT=0 instance covers the disabled-timeout behaviour. The
// reference model picks winners by scanning last+1, last+2, ... modulo 4.
module tb_mux4_bus_arbiter;

    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = '0;
    logic       bus_ack = 1'b0;
    logic [3:0] gnt, done, err;
    logic [1:0] sel;
    logic       bus_valid, busy;

    logic [3:0] req0 = '0;
    logic       ack0 = 1'b0;
    logic [3:0] gnt0, done0, err0;
    logic [1:0] sel0;
    logic       bus_valid0, busy0;

    int         n_assert = 0;
    int         n_fail = 0;
    logic [3:0] pending = '0;
    int         m_last = 3;
    int         waits[4];

    mux4_bus_arbiter #(.TIMEOUT(TMO), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .sel(sel),
        .bus_valid(bus_valid), .bus_ack(bus_ack), .done(done), .err(err), .busy(busy)
    );

    mux4_bus_arbiter #(.TIMEOUT(0), .CNT_W(5)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req0), .gnt(gnt0), .sel(sel0),
        .bus_valid(bus_valid0), .bus_ack(ack0), .done(done0), .err(err0), .busy(busy0)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    // Round-robin reference: first pending requester after 'last', cyclically.
    function automatic int model_pick(input logic [3:0] r, input int last);
        for (int k = 1; k <= 4; k++) begin
            int idx;
            idx = (last + k) % 4;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction on the main instance. ack_delay is the number of
    // cycles after the grant before bus_ack is raised; >= TMO means never.
    task automatic txn(input int ack_delay, input bit mid_adds, output int bv_cycles);
        int         pick;
        int         g;
        logic [3:0] exp_g;
        bit         fin;
        req   = pending;
        pick  = model_pick(pending, m_last);
        exp_g = 4'(1 << pick);
        step();
        n_assert++;
        if ({gnt, sel, bus_valid, busy} !== {exp_g, 2'(pick), 2'b11}) begin
            n_fail++;
            $display("FAIL grant: got gnt=%b sel=%0d valid=%b busy=%b, expected gnt=%b sel=%0d valid=1 busy=1",
                     gnt, sel, bus_valid, busy, exp_g, pick);
        end
        g = int'(sel);
        n_assert++;
        if (waits[g] > 3) begin
            n_fail++;
            $display("FAIL fairness: requester %0d waited %0d transactions, expected at most 3", g, waits[g]);
        end
        waits[g] = 0;
        for (int i = 0; i < 4; i++) if (i != g && pending[i]) waits[i]++;
        bv_cycles = 1;
        fin = 1'b0;
        for (int k = 0; k < TMO && !fin; k++) begin
            if (mid_adds && $urandom_range(0, 3) == 0) begin
                pending = pending | 4'($urandom_range(0, 15));
                req     = pending;
            end
            if (k == ack_delay) bus_ack = 1'b1;
            step();
            bus_ack = 1'b0;
            n_assert++;
            if (k == ack_delay) begin
                fin = 1'b1;
                if ({done, err, gnt, bus_valid} !== {exp_g, 4'b0, 4'b0, 1'b0}) begin
                    n_fail++;
                    $display("FAIL ack_end: got done=%b err=%b gnt=%b valid=%b, expected done=%b err=0000 gnt=0000 valid=0",
                             done, err, gnt, bus_valid, exp_g);
                end
            end else if (k == TMO - 1) begin
                fin = 1'b1;
                if ({done, err, gnt, bus_valid} !== {4'b0, exp_g, 4'b0, 1'b0}) begin
                    n_fail++;
                    $display("FAIL timeout_end: got done=%b err=%b gnt=%b valid=%b, expected done=0000 err=%b gnt=0000 valid=0",
                             done, err, gnt, bus_valid, exp_g);
                end
            end else begin
                if ({gnt, sel, bus_valid, done, err} !== {exp_g, 2'(pick), 1'b1, 8'b0}) begin
                    n_fail++;
                    $display("FAIL hold: cycle %0d got gnt=%b sel=%0d valid=%b done=%b err=%b, expected gnt=%b sel=%0d valid=1 no pulses",
                             k, gnt, sel, bus_valid, done, err, exp_g, pick);
                end
                bv_cycles++;
            end
        end
        pending[pick] = 1'b0;
        req    = pending;
        m_last = pick;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = '0;
        bus_ack = 1'b0;
        step();
        n_assert++;
        if ({gnt, sel, bus_valid, busy, done, err} !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_values: got gnt=%b sel=%0d valid=%b busy=%b done=%b err=%b, expected all zero",
                     gnt, sel, bus_valid, busy, done, err);
        end
        rst_n = 1'b1;
        m_last = 3;
        pending = '0;
        for (int i = 0; i < 4; i++) waits[i] = 0;
        step();
        step();
        n_assert++;
        if ({gnt, bus_valid, gnt0, bus_valid0} !== 10'h0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got gnt=%b valid=%b gnt0=%b valid0=%b, expected idle",
                     gnt, bus_valid, gnt0, bus_valid0);
        end
    endtask

    task automatic test_back_to_back();
        int exp_order[5] = '{0, 1, 2, 3, 0};
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            step();
            n_assert++;
            if (gnt !== 4'(1 << exp_order[n]) || sel !== 2'(exp_order[n])) begin
                n_fail++;
                $display("FAIL b2b_grant: slot %0d got gnt=%b sel=%0d, expected sel=%0d", n, gnt, sel, exp_order[n]);
            end
            step();
            bus_ack = 1'b1;
            step();
            bus_ack = 1'b0;
            if (n == 4) req = '0;
            n_assert++;
            if (done !== 4'(1 << exp_order[n]) || gnt !== 4'b0) begin
                n_fail++;
                $display("FAIL b2b_bubble: slot %0d got done=%b gnt=%b, expected done for %0d and gnt=0000",
                         n, done, gnt, exp_order[n]);
            end
        end
        m_last = 0;
        pending = '0;
    endtask

    task automatic test_single();
        int bv;
        pending = 4'b0001;
        txn(3, 1'b0, bv);
        n_assert++;
        if (bv !== 4) begin
            n_fail++;
            $display("FAIL single_valid_len: bus_valid high %0d cycles, expected 4", bv);
        end
        step();
        n_assert++;
        if (done !== 4'b0 || bus_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pulse: got done=%b valid=%b, expected done=0000 valid=0", done, bus_valid);
        end
    endtask

    task automatic test_timeout();
        int bv;
        pending = 4'b0101;
        txn(1000, 1'b0, bv);
        n_assert++;
        if (bv !== TMO) begin
            n_fail++;
            $display("FAIL timeout_len: gnt held %0d cycles, expected %0d", bv, TMO);
        end
        txn(0, 1'b0, bv);
    endtask

    task automatic test_ack_at_timeout();
        int bv;
        pending = 4'b1000;
        txn(TMO - 1, 1'b0, bv);
        step();
        n_assert++;
        if (err !== 4'b0 || done !== 4'b0) begin
            n_fail++;
            $display("FAIL ack_vs_timeout_after: got done=%b err=%b, expected both 0000", done, err);
        end
    endtask

    task automatic test_idle_ack();
        req = '0;
        bus_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_assert++;
            if ({done, err, gnt, bus_valid} !== 13'h0) begin
                n_fail++;
                $display("FAIL idle_ack: got done=%b err=%b gnt=%b valid=%b, expected all zero", done, err, gnt, bus_valid);
            end
        end
        bus_ack = 1'b0;
    endtask

    task automatic test_reset_busy();
        int bv;
        req = 4'b1000;
        step();
        n_assert++;
        if (sel !== 2'd3 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_busy_setup: got sel=%0d busy=%b, expected sel=3 busy=1", sel, busy);
        end
        step();
        step();
        rst_n = 1'b0;
        req = '0;
        #1;
        n_assert++;
        if ({gnt, sel, bus_valid, busy, done, err} !== 16'h0) begin
            n_fail++;
            $display("FAIL rst_async: got gnt=%b sel=%0d valid=%b busy=%b done=%b err=%b, expected all zero",
                     gnt, sel, bus_valid, busy, done, err);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_last = 3;
        pending = '0;
        for (int i = 0; i < 4; i++) waits[i] = 0;
        step();
        n_assert++;
        if ({done, err, gnt} !== 12'h0) begin
            n_fail++;
            $display("FAIL rst_silent: got done=%b err=%b gnt=%b, expected all zero", done, err, gnt);
        end
        pending = 4'b1001;
        txn(1, 1'b0, bv);
        txn(2, 1'b0, bv);
    endtask

    task automatic test_random();
        int bv;
        int d;
        for (int n = 0; n < 40; n++) begin
            pending = pending | 4'($urandom_range(0, 15));
            if (pending == 4'b0) pending = 4'($urandom_range(1, 15));
            d = $urandom_range(0, 19);
            txn(d, 1'b1, bv);
        end
        while (pending != 4'b0) txn(0, 1'b0, bv);
    endtask

    task automatic test_no_timeout();
        int bad;
        req0 = 4'b0010;
        step();
        n_assert++;
        if (gnt0 !== 4'b0010 || sel0 !== 2'd1) begin
            n_fail++;
            $display("FAIL nto_grant: got gnt=%b sel=%0d, expected gnt=0010 sel=1", gnt0, sel0);
        end
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (gnt0 !== 4'b0010 || err0 !== 4'b0 || done0 !== 4'b0 || bus_valid0 !== 1'b1) bad++;
        end
        n_assert++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL nto_hold: %0d of 1000 cycles lost the grant or pulsed, expected 0", bad);
        end
        ack0 = 1'b1;
        step();
        ack0 = 1'b0;
        req0 = '0;
        n_assert++;
        if (done0 !== 4'b0010 || err0 !== 4'b0 || gnt0 !== 4'b0) begin
            n_fail++;
            $display("FAIL nto_ack: got done=%b err=%b gnt=%b, expected done=0010 err=0000 gnt=0000", done0, err0, gnt0);
        end
        ack0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_assert++;
            if ({done0, err0, gnt0} !== 12'h0) begin
                n_fail++;
                $display("FAIL nto_idle_ack: got done=%b err=%b gnt=%b, expected all zero", done0, err0, gnt0);
            end
        end
        ack0 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_single();
        test_timeout();
        test_ack_at_timeout();
        test_idle_ack();
        test_reset_busy();
        test_random();
        test_no_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
